// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, PC step, bubble word and FSM states.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC   = XLEN'(4);
  localparam logic [XLEN-1:0] NOP_WORD = XLEN'(0);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction memory and
// feeds the IF/ID register one PC/instruction pair (or a zero bubble) per cycle.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(0),
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            valid_out
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] pc_next;

  assign pc_next = pc_q + PC_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next-state and combinational outputs; a branch always turns the cycle into a bubble.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hold_instr_d    = hold_instr_q;
    hold_pc_d       = hold_pc_q;
    redirect_pc_d   = redirect_pc_q;
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    PC_out          = '0;
    instruction_out = NOP_INSTR;
    valid_out       = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (branch_taken) begin
            pc_d = branch_addr;
          end else if (freeze) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_next;
            pc_d         = pc_next;
            state_d      = HOLD;
          end else begin
            PC_out          = pc_next;
            instruction_out = imem_rdata;
            valid_out       = 1'b1;
            pc_d            = pc_next;
          end
        end else if (branch_taken) begin
          // Request already in flight: let it finish, then drop its data.
          redirect_pc_d = branch_addr;
          state_d       = DISCARD;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d         = branch_addr;
          hold_instr_d = '0;
          hold_pc_d    = '0;
          state_d      = FETCH;
        end else begin
          PC_out          = hold_pc_q;
          instruction_out = hold_instr_q;
          valid_out       = 1'b1;
          if (!freeze) state_d = FETCH;
        end
      end

      DISCARD: begin
        imem_req = 1'b1;
        if (branch_taken) redirect_pc_d = branch_addr;
        if (imem_ready) begin
          pc_d    = branch_taken ? branch_addr : redirect_pc_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    if (rst) begin
      imem_req        = 1'b0;
      PC_out          = '0;
      instruction_out = NOP_INSTR;
      valid_out       = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit plus hand sequences for reset corners.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_val;
  } vec_t;

  vec_t        vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned held_loads = 0;
  int unsigned dropped_loads = 0;

  localparam logic [31:0] HELD_WORD = 32'hE3A0_0001;
  localparam logic [31:0] DROP_WORD = 32'h5555_5555;

  // Count words actually loaded downstream (valid and not frozen).
  always @(negedge clk) begin
    if (!rst && valid_out && !freeze) begin
      if (instruction_out == HELD_WORD) held_loads++;
      if (instruction_out == DROP_WORD) dropped_loads++;
    end
  end

  task automatic push_vec(input logic fr, input logic br, input logic [31:0] baddr,
                          input logic rdy, input logic [31:0] rdata,
                          input logic e_req, input logic [31:0] e_addr,
                          input logic [31:0] e_pc, input logic [31:0] e_ins,
                          input logic e_val);
    vec_t v;
    v.fr = fr; v.br = br; v.baddr = baddr; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ins = e_ins; v.e_val = e_val;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_val);
    n_vec++;
    chk({tag, " imem_req"}, 32'(imem_req), 32'(e_req));
    chk({tag, " imem_addr"}, imem_addr, e_addr);
    chk({tag, " PC_out"}, PC_out, e_pc);
    chk({tag, " instruction_out"}, instruction_out, e_ins);
    chk({tag, " valid_out"}, 32'(valid_out), 32'(e_val));
  endtask

  initial begin
    // fr br baddr rdy rdata | req addr pc ins val
    // zero-wait stream, data = address
    push_vec(0, 0, 32'h0,   1, 32'h0,         1, 32'h0,   32'h4,   32'h0,         1);
    push_vec(0, 0, 32'h0,   1, 32'h4,         1, 32'h4,   32'h8,   32'h4,         1);
    push_vec(0, 0, 32'h0,   1, 32'h8,         1, 32'h8,   32'hC,   32'h8,         1);
    // branch back to 0, then two wait states
    push_vec(0, 1, 32'h0,   1, 32'hC,         1, 32'hC,   32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   0, 32'h0,         1, 32'h0,   32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   0, 32'h0,         1, 32'h0,   32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'hAAAA_0000, 1, 32'h0,   32'h4,   32'hAAAA_0000, 1);
    // back to 0, freeze 3 cycles as the word returns
    push_vec(0, 1, 32'h0,   1, 32'h1111_1111, 1, 32'h4,   32'h0,   32'h0,         0);
    push_vec(1, 0, 32'h0,   1, HELD_WORD,     1, 32'h0,   32'h0,   32'h0,         0);
    push_vec(1, 0, 32'h0,   0, 32'h0,         0, 32'h4,   32'h4,   HELD_WORD,     1);
    push_vec(1, 0, 32'h0,   0, 32'h0,         0, 32'h4,   32'h4,   HELD_WORD,     1);
    push_vec(0, 0, 32'h0,   0, 32'h0,         0, 32'h4,   32'h4,   HELD_WORD,     1);
    push_vec(0, 0, 32'h0,   1, 32'h8,         1, 32'h4,   32'h8,   32'h8,         1);
    // branch while request to 8 is in flight
    push_vec(0, 1, 32'h100, 0, 32'h0,         1, 32'h8,   32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   0, 32'h0,         1, 32'h8,   32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h8,   32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'h100,       1, 32'h100, 32'h104, 32'h100,       1);
    // branch while holding a frozen word
    push_vec(1, 0, 32'h0,   1, DROP_WORD,     1, 32'h104, 32'h0,   32'h0,         0);
    push_vec(1, 1, 32'h200, 0, 32'h0,         0, 32'h108, 32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'h200,       1, 32'h200, 32'h204, 32'h200,       1);
    // two branches during one in-flight request: newest wins
    push_vec(0, 1, 32'h300, 0, 32'h0,         1, 32'h204, 32'h0,   32'h0,         0);
    push_vec(0, 1, 32'h400, 0, 32'h0,         1, 32'h204, 32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'h9999_9999, 1, 32'h204, 32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'h400,       1, 32'h400, 32'h404, 32'h400,       1);
    // PC wrap at the top of the address space
    push_vec(0, 1, 32'hFFFF_FFFC, 1, 32'h1,   1, 32'h404, 32'h0,   32'h0,         0);
    push_vec(0, 0, 32'h0,   1, 32'h1234_5678, 1, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 1);
    push_vec(0, 0, 32'h0,   1, 32'h0BAD_F00D, 1, 32'h0,   32'h4,   32'h0BAD_F00D, 1);

    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    @(negedge clk);
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      freeze       = vecs[i].fr;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      imem_ready   = vecs[i].rdy;
      imem_rdata   = vecs[i].rdata;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
              vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_val);
      @(posedge clk); #1;
    end

    n_vec++;
    chk("held word loads", 32'(held_loads), 32'd1);
    chk("dropped word loads", 32'(dropped_loads), 32'd0);

    // Reset asserted while a request to 4 is waiting
    freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    @(negedge clk);
    chk_all("wait before rst", 1'b1, 32'h4, 32'h0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'h5A5A_5A5A;
    #1;
    chk_all("mid-wait rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    chk_all("after rst", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    imem_ready = 1'b1; imem_rdata = 32'h77;
    @(negedge clk);
    chk_all("first after rst", 1'b1, 32'h0, 32'h4, 32'h77, 1'b1);
    @(posedge clk); #1;
    imem_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
